// File: rtl/counter_cmd_seq.sv
// Command sequencer for a 4-bit up/down counter: queues {op, data, len} commands
// and drives the counter's load/direction/data pins for len+1 cycles per command.
module counter_cmd_seq #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_data,
    input  logic [3:0] cmd_len,
    input  logic [3:0] COUNT_IN,
    output logic [3:0] D_OUT,
    output logic       LOAD,
    output logic       ASC_DESC,
    output logic       busy,
    output logic       done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_UP    = 2'b01,
        OP_DOWN  = 2'b10,
        OP_PAUSE = 2'b11
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [3:0] data;
        logic [3:0] len;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    cmd_t          mem_r [DEPTH];
    cmd_t          head_s;
    cmd_t          new_s;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;
    logic          ready_r;
    logic          push_s;
    logic          pop_s;
    logic          empty_s;

    state_e        state_r;
    state_e        state_s;
    logic [3:0]    remain_r;
    logic [3:0]    remain_s;
    op_e           op_r;
    op_e           op_s;
    logic [3:0]    d_out_r;
    logic [3:0]    d_out_s;
    logic          load_r;
    logic          load_s;
    logic          asc_r;
    logic          asc_s;
    logic          busy_r;
    logic          busy_s;
    logic          done_r;
    logic          done_s;

    assign head_s  = mem_r[rd_ptr_r];
    assign empty_s = (count_r == {CW{1'b0}});
    assign push_s  = cmd_valid & ready_r;

    // Incoming command record and next occupancy.
    always_comb begin
        new_s.op   = op_e'(cmd_op);
        new_s.data = cmd_data;
        new_s.len  = cmd_len;
        count_s    = count_r;
        if (push_s && !pop_s) begin
            count_s = count_r + CW'(1);
        end else if (!push_s && pop_s) begin
            count_s = count_r - CW'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Command FIFO storage, pointers and registered ready (low while in reset).
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            ready_r  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= cmd_t'({CMD_W{1'b0}});
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= new_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_s;
            ready_r <= (count_s != CW'(DEPTH));
        end
    end

    // Next-state and next-output logic; IDLE holds the counter like PAUSE.
    always_comb begin
        state_s  = state_r;
        remain_s = remain_r;
        op_s     = op_r;
        d_out_s  = d_out_r;
        load_s   = load_r;
        asc_s    = asc_r;
        done_s   = 1'b0;
        pop_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s  = 1'b0;
                d_out_s = COUNT_IN;
                if (!empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (op_r == OP_PAUSE) begin
                    d_out_s = COUNT_IN;
                end else begin
                    d_out_s = d_out_r;
                end
                if (remain_r != 4'd0) begin
                    remain_s = remain_r - 4'd1;
                end else if (!empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                    load_s  = 1'b0;
                    d_out_s = COUNT_IN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // A pop overrides the above with the head command's outputs.
        if (pop_s) begin
            state_s  = ST_RUN;
            remain_s = head_s.len;
            op_s     = head_s.op;
            case (head_s.op)
                OP_LOAD: begin
                    load_s  = 1'b0;
                    d_out_s = head_s.data;
                    asc_s   = 1'b1;
                end
                OP_UP: begin
                    load_s  = 1'b1;
                    d_out_s = d_out_r;
                    asc_s   = 1'b1;
                end
                OP_DOWN: begin
                    load_s  = 1'b1;
                    d_out_s = d_out_r;
                    asc_s   = 1'b0;
                end
                OP_PAUSE: begin
                    load_s  = 1'b0;
                    d_out_s = COUNT_IN;
                    asc_s   = asc_r;
                end
                default: begin
                    load_s  = 1'b0;
                    d_out_s = COUNT_IN;
                    asc_s   = asc_r;
                end
            endcase
        end else begin
            op_s = op_r;
        end
        busy_s = (state_s == ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            remain_r <= 4'd0;
            op_r     <= OP_PAUSE;
            d_out_r  <= 4'd0;
            load_r   <= 1'b0;
            asc_r    <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            remain_r <= remain_s;
            op_r     <= op_s;
            d_out_r  <= d_out_s;
            load_r   <= load_s;
            asc_r    <= asc_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign cmd_ready = ready_r;
    assign D_OUT     = d_out_r;
    assign LOAD      = load_r;
    assign ASC_DESC  = asc_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Self-checking bench for counter_cmd_seq: per-cycle vectors with expected outputs
// queued on drive and compared one time unit after the following rising edge.
module tb_counter_cmd_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_data = 4'h0;
    logic [3:0] cmd_len = 4'h0;
    logic [3:0] COUNT_IN = 4'h0;
    logic [3:0] D_OUT;
    logic       LOAD;
    logic       ASC_DESC;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] op;
        logic [3:0] data;
        logic [3:0] len;
        logic [3:0] cin;
        logic       rdy;
        logic       ld;
        logic       asc;
        logic [3:0] d;
        logic       busy;
        logic       done;
        string      name;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    counter_cmd_seq #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .cmd_len  (cmd_len),
        .COUNT_IN (COUNT_IN),
        .D_OUT    (D_OUT),
        .LOAD     (LOAD),
        .ASC_DESC (ASC_DESC),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] op,
                                input logic [3:0] data, input logic [3:0] len,
                                input logic [3:0] cin, input logic rdy, input logic ld,
                                input logic asc, input logic [3:0] d, input logic bsy,
                                input logic dn, input string name);
        vec_t x;
        x.rst = r;   x.vld = v;   x.op = op;   x.data = data; x.len = len; x.cin = cin;
        x.rdy = rdy; x.ld = ld;   x.asc = asc; x.d = d;       x.busy = bsy; x.done = dn;
        x.name = name;
        return x;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [3:0] got,
                       input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s.%s cycle %0d: got %0h expected %0h", nm, fld, cyc, got, exp);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst; cmd_valid = v.vld; cmd_op = v.op;
        cmd_data = v.data; cmd_len = v.len; COUNT_IN = v.cin;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        chk(e.name, "cmd_ready", {3'b000, cmd_ready}, {3'b000, e.rdy});
        chk(e.name, "LOAD",      {3'b000, LOAD},      {3'b000, e.ld});
        chk(e.name, "ASC_DESC",  {3'b000, ASC_DESC},  {3'b000, e.asc});
        chk(e.name, "D_OUT",     D_OUT,               e.d);
        chk(e.name, "busy",      {3'b000, busy},      {3'b000, e.busy});
        chk(e.name, "done",      {3'b000, done},      {3'b000, e.done});
    endtask

    initial begin
        // Reset, idle tracking, LOAD then UP back-to-back, PAUSE tracking COUNT_IN.
        tbl.push_back(mk(0, 0, 2'd0, 4'h0, 4'd0, 4'h0, 0, 0, 1, 4'h0, 0, 0, "reset0"));
        tbl.push_back(mk(0, 0, 2'd0, 4'h0, 4'd0, 4'h0, 0, 0, 1, 4'h0, 0, 0, "reset1"));
        tbl.push_back(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'hA, 1, 0, 1, 4'hA, 0, 0, "idle0"));
        tbl.push_back(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'hA, 1, 0, 1, 4'hA, 0, 0, "idle1"));
        tbl.push_back(mk(1, 1, 2'd0, 4'h9, 4'd0, 4'hA, 1, 0, 1, 4'hA, 0, 0, "push_load"));
        tbl.push_back(mk(1, 1, 2'd1, 4'h0, 4'd2, 4'hA, 1, 0, 1, 4'h9, 1, 0, "load_run"));
        tbl.push_back(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'hA, 1, 1, 1, 4'h9, 1, 0, "up1"));
        tbl.push_back(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'hA, 1, 1, 1, 4'h9, 1, 0, "up2"));
        tbl.push_back(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'hA, 1, 1, 1, 4'h9, 1, 0, "up3"));
        tbl.push_back(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'hA, 1, 0, 1, 4'hA, 0, 1, "up_done"));
        tbl.push_back(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'hA, 1, 0, 1, 4'hA, 0, 0, "idle2"));
        tbl.push_back(mk(1, 1, 2'd3, 4'h0, 4'd3, 4'hA, 1, 0, 1, 4'hA, 0, 0, "push_pause"));
        tbl.push_back(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h4, 1, 0, 1, 4'h4, 1, 0, "pause1"));
        tbl.push_back(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h5, 1, 0, 1, 4'h5, 1, 0, "pause2"));
        tbl.push_back(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h6, 1, 0, 1, 4'h6, 1, 0, "pause3"));
        tbl.push_back(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h7, 1, 0, 1, 4'h7, 1, 0, "pause4"));
        tbl.push_back(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h8, 1, 0, 1, 4'h8, 0, 1, "pause_done"));
        tbl.push_back(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h8, 1, 0, 1, 4'h8, 0, 0, "idle3"));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // DOWN len=15: sixteen run cycles, then done; direction stays down in IDLE.
        step(mk(1, 1, 2'd2, 4'h0, 4'd15, 4'h8, 1, 0, 1, 4'h8, 0, 0, "push_down15"));
        for (int i = 0; i < 16; i++) begin
            step(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h8, 1, 1, 0, 4'h8, 1, 0, "down15_run"));
        end
        step(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h8, 1, 0, 0, 4'h8, 0, 1, "down15_done"));
        step(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h8, 1, 0, 0, 4'h8, 0, 0, "down15_idle"));

        // FIFO full while UP len=5 runs; 5th offer waits until the first entry pops.
        step(mk(1, 1, 2'd1, 4'h0, 4'd5,  4'h8, 1, 0, 0, 4'h8, 0, 0, "full_push_up5"));
        step(mk(1, 1, 2'd0, 4'h3, 4'd15, 4'h8, 1, 1, 1, 4'h8, 1, 0, "full_push1"));
        step(mk(1, 1, 2'd2, 4'h0, 4'd0,  4'h8, 1, 1, 1, 4'h8, 1, 0, "full_push2"));
        step(mk(1, 1, 2'd3, 4'h0, 4'd0,  4'h8, 1, 1, 1, 4'h8, 1, 0, "full_push3"));
        step(mk(1, 1, 2'd1, 4'h0, 4'd0,  4'h8, 0, 1, 1, 4'h8, 1, 0, "full_push4"));
        step(mk(1, 1, 2'd2, 4'h0, 4'd1,  4'h8, 0, 1, 1, 4'h8, 1, 0, "full_reject5a"));
        step(mk(1, 1, 2'd2, 4'h0, 4'd1,  4'h8, 0, 1, 1, 4'h8, 1, 0, "full_reject5b"));
        step(mk(1, 1, 2'd2, 4'h0, 4'd1,  4'h8, 1, 0, 1, 4'h3, 1, 0, "full_pop_noacc"));
        step(mk(1, 1, 2'd2, 4'h0, 4'd1,  4'h8, 0, 0, 1, 4'h3, 1, 0, "full_accept5"));
        for (int i = 0; i < 14; i++) begin
            step(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h8, 0, 0, 1, 4'h3, 1, 0, "full_load_run"));
        end
        step(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h8, 1, 1, 0, 4'h3, 1, 0, "chain_down"));
        step(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h8, 1, 0, 0, 4'h8, 1, 0, "chain_pause"));
        step(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h8, 1, 1, 1, 4'h8, 1, 0, "chain_up"));
        step(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h8, 1, 1, 0, 4'h8, 1, 0, "chain_down1a"));
        step(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h8, 1, 1, 0, 4'h8, 1, 0, "chain_down1b"));
        step(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h8, 1, 0, 0, 4'h8, 0, 1, "chain_done"));
        step(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h8, 1, 0, 0, 4'h8, 0, 0, "chain_idle"));

        // Reset during the 2nd cycle of UP len=5 with two entries queued.
        step(mk(1, 1, 2'd1, 4'h0, 4'd5, 4'h8, 1, 0, 0, 4'h8, 0, 0, "abort_push_up"));
        step(mk(1, 1, 2'd0, 4'h5, 4'd0, 4'h8, 1, 1, 1, 4'h8, 1, 0, "abort_push_q1"));
        step(mk(1, 1, 2'd2, 4'h0, 4'd0, 4'h8, 1, 1, 1, 4'h8, 1, 0, "abort_push_q2"));
        step(mk(0, 0, 2'd0, 4'h0, 4'd0, 4'h8, 0, 0, 1, 4'h0, 0, 0, "abort_reset"));
        step(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h2, 1, 0, 1, 4'h2, 0, 0, "abort_release"));
        step(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h2, 1, 0, 1, 4'h2, 0, 0, "abort_empty1"));
        step(mk(1, 0, 2'd0, 4'h0, 4'd0, 4'h2, 1, 0, 1, 4'h2, 0, 0, "abort_empty2"));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
